// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS controller.
//   - opcode and funct field values of the supported instructions
//   - ALU control encodings driven on alu_ctrl
//   - controller state enumeration (4-bit, exported on state_dbg)
//   - helpers that classify and translate R-type funct codes
package mips_pkg;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, IR[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    function automatic logic funct_supported(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
        logic [2:0] alu;
        case (fn)
            FN_ADD:  alu = ALU_ADD;
            FN_SUB:  alu = ALU_SUB;
            FN_AND:  alu = ALU_AND;
            FN_OR:   alu = ALU_OR;
            FN_SLT:  alu = ALU_SLT;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// mips_wait_timer: cycle counter guarding every memory wait of the controller.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-low
//   clear   - return the count to zero (takes priority over count)
//   count   - a wait cycle has elapsed with ready still low
//   expired - this wait cycle brings the count to LIMIT (combinational)
module mips_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    // The limit is tested against the incremented value, so LIMIT counted
    // wait cycles end the wait rather than LIMIT+1.
    assign cnt_next = cnt_reg + 1'b1;
    assign expired  = count && (cnt_next == W'(LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (count) begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM. Sequences fetch, decode,
// execute, memory and write-back for one instruction at a time.
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-low reset
//   op, funct             - opcode and funct fields of the latched IR
//   zf                    - ALU zero flag (consumed by the fetch unit)
//   imem_ready            - instruction word valid
//   dmem_ready            - data memory access complete
//   imem_read, ir_write   - instruction fetch request, IR latch enable
//   pc_en, branch, jump   - PC update enable and target selects
//   alu_src_imm, ext_sign - ALU B operand from imm16, sign/zero extension
//   alu_ctrl              - ALU operation
//   reg_dst_rd, mem_to_reg, reg_write - register file write controls
//   mem_read, mem_write   - data memory requests
//   illegal, bus_err      - sticky trap causes
//   retired               - retired instruction count
//   state_dbg             - current state encoding
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zf,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_read,
    output logic             ir_write,
    output logic             pc_en,
    output logic             branch,
    output logic             jump,
    output logic             alu_src_imm,
    output logic             ext_sign,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst_rd,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t           state_reg;
    state_t           state_next;
    logic             illegal_reg;
    logic             bus_err_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             wait_count;
    logic             wait_expired;
    logic             zf_unused;

    // Branch target selection by zf happens in the fetch unit; the
    // controller only raises the branch select.
    assign zf_unused = zf;

    // A wait cycle is one spent in a wait state whose ready is still low.
    assign wait_count = ((state_reg == S_FETCH)  && !imem_ready) ||
                        ((state_reg == S_MEM_RD) && !dmem_ready) ||
                        ((state_reg == S_MEM_WR) && !dmem_ready);

    // Every state change restarts the timer, so each wait state is entered
    // with a zero count, including MEM_RD/MEM_WR -> FETCH.
    mips_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state_reg),
        .count   (wait_count),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, pc_en};
            if ((state_reg == S_DECODE) && (state_next == S_TRAP)) begin
                illegal_reg <= 1'b1;
            end
            if (wait_expired) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        imem_read   = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_src_imm = 1'b0;
        ext_sign    = 1'b0;
        alu_ctrl    = ALU_AND;
        reg_dst_rd  = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_read = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_next = funct_supported(funct) ? S_EXEC_R : S_TRAP;
                    OP_ADDI,
                    OP_ORI:        state_next = S_EXEC_I;
                    OP_LW,
                    OP_SW:         state_next = S_MEM_ADDR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_ctrl   = funct_to_alu(funct);
                state_next = S_R_WB;
            end
            S_R_WB: begin
                alu_ctrl   = funct_to_alu(funct);
                reg_dst_rd = 1'b1;
                reg_write  = 1'b1;
                pc_en      = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I, S_I_WB: begin
                alu_src_imm = 1'b1;
                ext_sign    = (op == OP_ADDI);
                alu_ctrl    = (op == OP_ADDI) ? ALU_ADD : ALU_OR;
                if (state_reg == S_EXEC_I) begin
                    state_next = S_I_WB;
                end else begin
                    reg_write  = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_src_imm = 1'b1;
                ext_sign    = 1'b1;
                alu_ctrl    = ALU_ADD;
                state_next  = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                // Address path stays stable for the whole access.
                alu_src_imm = 1'b1;
                ext_sign    = 1'b1;
                alu_ctrl    = ALU_ADD;
                mem_read    = 1'b1;
                if (dmem_ready) begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_FETCH;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_MEM_WR: begin
                alu_src_imm = 1'b1;
                ext_sign    = 1'b1;
                alu_ctrl    = ALU_ADD;
                mem_write   = 1'b1;
                if (dmem_ready) begin
                    pc_en      = 1'b1;
                    state_next = S_FETCH;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_BRANCH: begin
                alu_ctrl   = ALU_SUB;
                branch     = 1'b1;
                pc_en      = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                jump       = 1'b1;
                pc_en      = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // The state register already sits in FETCH during reset; this keeps
        // FETCH's fetch request (and everything else) quiet until release.
        if (!reset) begin
            imem_read   = 1'b0;
            ir_write    = 1'b0;
            pc_en       = 1'b0;
            branch      = 1'b0;
            jump        = 1'b0;
            alu_src_imm = 1'b0;
            reg_dst_rd  = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
        end
    end

    assign illegal   = illegal_reg;
    assign bus_err   = bus_err_reg;
    assign retired   = retired_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed self-checking bench for mips_mc_ctrl.
// Each task drives one scenario cycle by cycle and compares the state and
// strobe vector against hand-written expectations, sampled on the falling edge.
module tb_mips_mc_ctrl;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 4;

    localparam logic [3:0] ST_FETCH    = 4'(mips_pkg::S_FETCH);
    localparam logic [3:0] ST_DECODE   = 4'(mips_pkg::S_DECODE);
    localparam logic [3:0] ST_EXEC_R   = 4'(mips_pkg::S_EXEC_R);
    localparam logic [3:0] ST_R_WB     = 4'(mips_pkg::S_R_WB);
    localparam logic [3:0] ST_EXEC_I   = 4'(mips_pkg::S_EXEC_I);
    localparam logic [3:0] ST_I_WB     = 4'(mips_pkg::S_I_WB);
    localparam logic [3:0] ST_MEM_ADDR = 4'(mips_pkg::S_MEM_ADDR);
    localparam logic [3:0] ST_MEM_RD   = 4'(mips_pkg::S_MEM_RD);
    localparam logic [3:0] ST_MEM_WR   = 4'(mips_pkg::S_MEM_WR);
    localparam logic [3:0] ST_BRANCH   = 4'(mips_pkg::S_BRANCH);
    localparam logic [3:0] ST_JUMP     = 4'(mips_pkg::S_JUMP);
    localparam logic [3:0] ST_TRAP     = 4'(mips_pkg::S_TRAP);

    // Strobe vector bit masks
    localparam logic [10:0] IMRD = 11'h400;
    localparam logic [10:0] IRW  = 11'h200;
    localparam logic [10:0] PCEN = 11'h100;
    localparam logic [10:0] BR   = 11'h080;
    localparam logic [10:0] JMP  = 11'h040;
    localparam logic [10:0] IMM  = 11'h020;
    localparam logic [10:0] RDST = 11'h010;
    localparam logic [10:0] M2R  = 11'h008;
    localparam logic [10:0] RW   = 11'h004;
    localparam logic [10:0] MRD  = 11'h002;
    localparam logic [10:0] MWR  = 11'h001;
    localparam logic [10:0] NONE = 11'h000;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zf;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_read;
    logic             ir_write;
    logic             pc_en;
    logic             branch;
    logic             jump;
    logic             alu_src_imm;
    logic             ext_sign;
    logic [2:0]       alu_ctrl;
    logic             reg_dst_rd;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;
    logic [10:0]      strobes;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign strobes = {imem_read, ir_write, pc_en, branch, jump, alu_src_imm,
                      reg_dst_rd, mem_to_reg, reg_write, mem_read, mem_write};

    mips_mc_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zf          (zf),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_read   (imem_read),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .branch      (branch),
        .jump        (jump),
        .alu_src_imm (alu_src_imm),
        .ext_sign    (ext_sign),
        .alu_ctrl    (alu_ctrl),
        .reg_dst_rd  (reg_dst_rd),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .retired     (retired),
        .state_dbg   (state_dbg)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op = 6'd0; funct = 6'd0; zf = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        tests++;
        if ({state_dbg, strobes, illegal, bus_err} !== {ST_FETCH, NONE, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_hold: state/strobes/ill/berr got %h/%h/%b/%b want %h/%h/0/0",
                     state_dbg, strobes, illegal, bus_err, ST_FETCH, NONE);
        end
        tests++;
        if (retired !== '0) begin
            fails++;
            $display("FAIL reset_retired: got %0d want 0", retired);
        end
        next_cycle();
        reset = 1'b1;
        sample();
        tests++;
        if ({state_dbg, strobes} !== {ST_FETCH, IMRD}) begin
            fails++;
            $display("FAIL reset_release: state/strobes got %h/%h want %h/%h",
                     state_dbg, strobes, ST_FETCH, IMRD);
        end
        $display("[TB] reset: state=%0d retired=%0d", state_dbg, retired);
        next_cycle();
    endtask

    task automatic test_rtype();
        logic [5:0]       fn_tab  [5];
        logic [2:0]       alu_tab [5];
        logic [3:0]       st_exp  [4];
        logic [10:0]      sb_exp  [4];
        logic [CNT_W-1:0] r0;
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        st_exp  = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_R_WB};
        sb_exp  = '{IMRD | IRW, NONE, NONE, RDST | RW | PCEN};
        for (int i = 0; i < 5; i++) begin
            op = 6'b000000; funct = fn_tab[i]; imem_ready = 1'b1; dmem_ready = 1'b0;
            r0 = retired;
            for (int c = 0; c < 4; c++) begin
                sample();
                tests++;
                if ({state_dbg, strobes} !== {st_exp[c], sb_exp[c]}) begin
                    fails++;
                    $display("FAIL rtype_c%0d funct=%b: state/strobes got %h/%h want %h/%h",
                             c + 1, fn_tab[i], state_dbg, strobes, st_exp[c], sb_exp[c]);
                end
                if (c >= 2) begin
                    tests++;
                    if (alu_ctrl !== alu_tab[i]) begin
                        fails++;
                        $display("FAIL rtype_alu funct=%b: got %b want %b", fn_tab[i], alu_ctrl, alu_tab[i]);
                    end
                end
                next_cycle();
            end
            tests++;
            if ({state_dbg, retired} !== {ST_FETCH, r0 + 32'd1}) begin
                fails++;
                $display("FAIL rtype_retire funct=%b: state/retired got %h/%0d want %h/%0d",
                         fn_tab[i], state_dbg, retired, ST_FETCH, r0 + 32'd1);
            end
            $display("[TB] rtype funct=%b alu=%b retired=%0d", fn_tab[i], alu_tab[i], retired);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  st_exp [4];
        st_exp = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD};
        op = 6'b100011; funct = 6'd0; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            tests++;
            if (state_dbg !== st_exp[c]) begin
                fails++;
                $display("FAIL rstmid_c%0d: state got %h want %h", c + 1, state_dbg, st_exp[c]);
            end
            if (c < 3) next_cycle();
        end
        tests++;
        if (retired !== 32'd5) begin
            fails++;
            $display("FAIL rstmid_pre_retired: got %0d want 5", retired);
        end
        #1;
        reset = 1'b0;
        dmem_ready = 1'b1;
        #1;
        tests++;
        if ({state_dbg, strobes, retired} !== {ST_FETCH, NONE, 32'd0}) begin
            fails++;
            $display("FAIL rstmid_async: state/strobes/retired got %h/%h/%0d want %h/%h/0",
                     state_dbg, strobes, retired, ST_FETCH, NONE);
        end
        next_cycle();
        sample();
        tests++;
        if ({state_dbg, strobes} !== {ST_FETCH, NONE}) begin
            fails++;
            $display("FAIL rstmid_hold: state/strobes got %h/%h want %h/%h", state_dbg, strobes, ST_FETCH, NONE);
        end
        next_cycle();
        reset = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            tests++;
            if ({state_dbg, pc_en, reg_write} !== {ST_FETCH, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL rstmid_after_c%0d: state/pc_en/reg_write got %h/%b/%b want %h/0/0",
                         c + 1, state_dbg, pc_en, reg_write, ST_FETCH);
            end
            next_cycle();
        end
        tests++;
        if (retired !== 32'd0) begin
            fails++;
            $display("FAIL rstmid_retired: got %0d want 0", retired);
        end
        $display("[TB] reset mid MEM_RD: state=%0d retired=%0d", state_dbg, retired);
    endtask

    task automatic test_itype();
        logic [5:0]       op_tab  [2];
        logic             ext_tab [2];
        logic [2:0]       alu_tab [2];
        logic [3:0]       st_exp  [4];
        logic [10:0]      sb_exp  [4];
        logic [CNT_W-1:0] r0;
        op_tab  = '{6'b001000, 6'b001101};
        ext_tab = '{1'b1, 1'b0};
        alu_tab = '{3'b010, 3'b001};
        st_exp  = '{ST_FETCH, ST_DECODE, ST_EXEC_I, ST_I_WB};
        sb_exp  = '{IMRD | IRW, NONE, IMM, IMM | RW | PCEN};
        for (int i = 0; i < 2; i++) begin
            op = op_tab[i]; funct = 6'b100010; imem_ready = 1'b1; dmem_ready = 1'b0;
            r0 = retired;
            for (int c = 0; c < 4; c++) begin
                sample();
                tests++;
                if ({state_dbg, strobes} !== {st_exp[c], sb_exp[c]}) begin
                    fails++;
                    $display("FAIL itype_c%0d op=%b: state/strobes got %h/%h want %h/%h",
                             c + 1, op_tab[i], state_dbg, strobes, st_exp[c], sb_exp[c]);
                end
                if (c >= 2) begin
                    tests++;
                    if ({ext_sign, alu_ctrl} !== {ext_tab[i], alu_tab[i]}) begin
                        fails++;
                        $display("FAIL itype_alu op=%b: ext/alu got %b/%b want %b/%b",
                                 op_tab[i], ext_sign, alu_ctrl, ext_tab[i], alu_tab[i]);
                    end
                end
                next_cycle();
            end
            tests++;
            if ({state_dbg, retired} !== {ST_FETCH, r0 + 32'd1}) begin
                fails++;
                $display("FAIL itype_retire op=%b: state/retired got %h/%0d want %h/%0d",
                         op_tab[i], state_dbg, retired, ST_FETCH, r0 + 32'd1);
            end
            $display("[TB] itype op=%b retired=%0d", op_tab[i], retired);
        end
    endtask

    task automatic test_lw();
        logic [3:0]       st_exp [7];
        logic [10:0]      sb_exp [7];
        logic [CNT_W-1:0] r0;
        int               mrd_cycles;
        st_exp = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD};
        sb_exp = '{IMRD | IRW, NONE, IMM, IMM | MRD, IMM | MRD, IMM | MRD,
                   IMM | MRD | M2R | RW | PCEN};
        op = 6'b100011; funct = 6'd0; imem_ready = 1'b1;
        r0 = retired;
        mrd_cycles = 0;
        for (int c = 0; c < 7; c++) begin
            dmem_ready = (c == 6);
            sample();
            if (mem_read) mrd_cycles++;
            tests++;
            if ({state_dbg, strobes} !== {st_exp[c], sb_exp[c]}) begin
                fails++;
                $display("FAIL lw_c%0d: state/strobes got %h/%h want %h/%h",
                         c + 1, state_dbg, strobes, st_exp[c], sb_exp[c]);
            end
            if (c >= 2) begin
                tests++;
                if ({ext_sign, alu_ctrl} !== {1'b1, 3'b010}) begin
                    fails++;
                    $display("FAIL lw_addr_c%0d: ext/alu got %b/%b want 1/010", c + 1, ext_sign, alu_ctrl);
                end
            end
            next_cycle();
        end
        dmem_ready = 1'b0;
        tests++;
        if ({state_dbg, retired} !== {ST_FETCH, r0 + 32'd1}) begin
            fails++;
            $display("FAIL lw_retire: state/retired got %h/%0d want %h/%0d",
                     state_dbg, retired, ST_FETCH, r0 + 32'd1);
        end
        tests++;
        if (mrd_cycles !== 4) begin
            fails++;
            $display("FAIL lw_mem_read_cycles: got %0d want 4", mrd_cycles);
        end
        $display("[TB] lw ready+3 mem_read_cycles=%0d retired=%0d", mrd_cycles, retired);
    endtask

    task automatic test_sw();
        logic [3:0]       st_exp [5];
        logic [10:0]      sb_exp [5];
        logic [CNT_W-1:0] r0;
        st_exp = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_MEM_WR};
        sb_exp = '{IMRD | IRW, NONE, IMM, IMM | MWR, IMM | MWR | PCEN};
        op = 6'b101011; funct = 6'd0; imem_ready = 1'b1;
        r0 = retired;
        for (int c = 0; c < 5; c++) begin
            dmem_ready = (c == 4);
            sample();
            tests++;
            if ({state_dbg, strobes} !== {st_exp[c], sb_exp[c]}) begin
                fails++;
                $display("FAIL sw_c%0d: state/strobes got %h/%h want %h/%h",
                         c + 1, state_dbg, strobes, st_exp[c], sb_exp[c]);
            end
            next_cycle();
        end
        dmem_ready = 1'b0;
        tests++;
        if ({state_dbg, retired} !== {ST_FETCH, r0 + 32'd1}) begin
            fails++;
            $display("FAIL sw_retire: state/retired got %h/%0d want %h/%0d",
                     state_dbg, retired, ST_FETCH, r0 + 32'd1);
        end
        $display("[TB] sw ready+1 retired=%0d", retired);
    endtask

    task automatic test_beq();
        logic             zf_tab [2];
        logic [3:0]       st_exp [3];
        logic [10:0]      sb_exp [3];
        logic [CNT_W-1:0] r0;
        zf_tab = '{1'b1, 1'b0};
        st_exp = '{ST_FETCH, ST_DECODE, ST_BRANCH};
        sb_exp = '{IMRD | IRW, NONE, BR | PCEN};
        r0 = retired;
        for (int i = 0; i < 2; i++) begin
            op = 6'b000100; funct = 6'd0; zf = zf_tab[i]; imem_ready = 1'b1; dmem_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                sample();
                tests++;
                if ({state_dbg, strobes} !== {st_exp[c], sb_exp[c]}) begin
                    fails++;
                    $display("FAIL beq_c%0d zf=%b: state/strobes got %h/%h want %h/%h",
                             c + 1, zf_tab[i], state_dbg, strobes, st_exp[c], sb_exp[c]);
                end
                if (c == 2) begin
                    tests++;
                    if (alu_ctrl !== 3'b110) begin
                        fails++;
                        $display("FAIL beq_alu zf=%b: got %b want 110", zf_tab[i], alu_ctrl);
                    end
                end
                next_cycle();
            end
            $display("[TB] beq zf=%b retired=%0d", zf_tab[i], retired);
        end
        zf = 1'b0; dmem_ready = 1'b0;
        tests++;
        if ({state_dbg, retired} !== {ST_FETCH, r0 + 32'd2}) begin
            fails++;
            $display("FAIL beq_retire: state/retired got %h/%0d want %h/%0d",
                     state_dbg, retired, ST_FETCH, r0 + 32'd2);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op_tab [2];
        logic [5:0] fn_tab [2];
        op_tab = '{6'b111111, 6'b000000};
        fn_tab = '{6'b000000, 6'b111111};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            op = op_tab[i]; funct = fn_tab[i]; imem_ready = 1'b1;
            sample();
            next_cycle();
            sample();
            tests++;
            if ({state_dbg, illegal} !== {ST_DECODE, 1'b0}) begin
                fails++;
                $display("FAIL illegal_decode op=%b fn=%b: state/illegal got %h/%b want %h/0",
                         op_tab[i], fn_tab[i], state_dbg, illegal, ST_DECODE);
            end
            next_cycle();
            for (int c = 0; c < 20; c++) begin
                sample();
                tests++;
                if ({state_dbg, strobes, illegal, bus_err} !== {ST_TRAP, NONE, 1'b1, 1'b0}) begin
                    fails++;
                    $display("FAIL illegal_trap_c%0d op=%b fn=%b: state/strobes/ill/berr got %h/%h/%b/%b want %h/%h/1/0",
                             c, op_tab[i], fn_tab[i], state_dbg, strobes, illegal, bus_err, ST_TRAP, NONE);
                end
                next_cycle();
            end
            $display("[TB] illegal op=%b funct=%b state=%0d illegal=%b", op_tab[i], fn_tab[i], state_dbg, illegal);
        end
    endtask

    task automatic test_timeout();
        // imem_ready stuck low: TIMEOUT wait cycles then TRAP with bus_err
        do_reset();
        op = 6'b000010; funct = 6'd0;
        for (int c = 0; c < TIMEOUT; c++) begin
            sample();
            tests++;
            if ({state_dbg, strobes, bus_err} !== {ST_FETCH, IMRD, 1'b0}) begin
                fails++;
                $display("FAIL timeout_wait_c%0d: state/strobes/berr got %h/%h/%b want %h/%h/0",
                         c + 1, state_dbg, strobes, bus_err, ST_FETCH, IMRD);
            end
            next_cycle();
        end
        sample();
        tests++;
        if ({state_dbg, strobes, bus_err} !== {ST_TRAP, NONE, 1'b1}) begin
            fails++;
            $display("FAIL timeout_trap: state/strobes/berr got %h/%h/%b want %h/%h/1",
                     state_dbg, strobes, bus_err, ST_TRAP, NONE);
        end
        $display("[TB] timeout stuck: state=%0d bus_err=%b", state_dbg, bus_err);
        next_cycle();

        // ready on the last allowed wait cycle wins; then a jump completes
        do_reset();
        op = 6'b000010; funct = 6'd0;
        for (int c = 0; c < TIMEOUT; c++) begin
            imem_ready = (c == TIMEOUT - 1);
            sample();
            tests++;
            if ({state_dbg, strobes} !== {ST_FETCH, (c == TIMEOUT - 1) ? (IMRD | IRW) : IMRD}) begin
                fails++;
                $display("FAIL late_ready_c%0d: state/strobes got %h/%h", c + 1, state_dbg, strobes);
            end
            next_cycle();
        end
        imem_ready = 1'b0;
        sample();
        tests++;
        if ({state_dbg, bus_err} !== {ST_DECODE, 1'b0}) begin
            fails++;
            $display("FAIL late_ready_decode: state/berr got %h/%b want %h/0", state_dbg, bus_err, ST_DECODE);
        end
        next_cycle();
        sample();
        tests++;
        if ({state_dbg, strobes} !== {ST_JUMP, JMP | PCEN}) begin
            fails++;
            $display("FAIL jump: state/strobes got %h/%h want %h/%h", state_dbg, strobes, ST_JUMP, JMP | PCEN);
        end
        next_cycle();
        tests++;
        if ({state_dbg, retired, bus_err} !== {ST_FETCH, 32'd1, 1'b0}) begin
            fails++;
            $display("FAIL late_ready_end: state/retired/berr got %h/%0d/%b want %h/1/0",
                     state_dbg, retired, bus_err, ST_FETCH);
        end
        $display("[TB] timeout late ready + j: state=%0d retired=%0d bus_err=%b", state_dbg, retired, bus_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_reset_mid();
        test_itype();
        test_lw();
        test_sw();
        test_beq();
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
